// File: rtl/mem_arbiter_pkg.sv
// mem_arb_types: shared types and widths for the memory arbiter and the caches
// that sit on either side of it.
package mem_arb_types;

    // Cacheline and byte-address widths shared with the cache packages.
    localparam int ARB_LINE_WIDTH = 256;
    localparam int ARB_ADDR_WIDTH = 32;

    // Arbiter controller states.
    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_SERVE_I = 2'd1,
        ARB_SERVE_D = 2'd2,
        ARB_RELEASE = 2'd3
    } arb_state_t;

    // Which requester owns (or is about to own) the memory port.
    typedef enum logic {
        ARB_SRC_I = 1'b0,
        ARB_SRC_D = 1'b1
    } arb_src_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the I-cache, D-cache and physical-memory signals
// around the arbiter. Modport "slave" is the arbiter's view; "master" is the
// view of the surrounding caches and memory.
//
// Handshake: x_read / x_write are levels raised by a requester and held until
// its x_resp, which is a single-cycle pulse; x_rdata is valid only in that
// pulse cycle and 0 otherwise. On the memory side pmem_read / pmem_write and
// pmem_addr / pmem_wdata are held constant until memory answers with a
// single-cycle pmem_resp (pmem_rdata is sampled in that cycle).
interface mem_arbiter_if
    import mem_arb_types::*;
#(
    parameter int LINE_WIDTH = ARB_LINE_WIDTH,
    parameter int ADDR_WIDTH = ARB_ADDR_WIDTH
);
    // I-cache side
    logic                  i_read;
    logic [ADDR_WIDTH-1:0] i_addr;
    logic [LINE_WIDTH-1:0] i_rdata;
    logic                  i_resp;
    // D-cache side
    logic                  d_read;
    logic                  d_write;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [LINE_WIDTH-1:0] d_wdata;
    logic [LINE_WIDTH-1:0] d_rdata;
    logic                  d_resp;
    // Physical memory side
    logic                  pmem_read;
    logic                  pmem_write;
    logic [ADDR_WIDTH-1:0] pmem_addr;
    logic [LINE_WIDTH-1:0] pmem_wdata;
    logic [LINE_WIDTH-1:0] pmem_rdata;
    logic                  pmem_resp;

    modport slave (
        input  i_read, i_addr,
        output i_rdata, i_resp,
        input  d_read, d_write, d_addr, d_wdata,
        output d_rdata, d_resp,
        output pmem_read, pmem_write, pmem_addr, pmem_wdata,
        input  pmem_rdata, pmem_resp
    );

    modport master (
        output i_read, i_addr,
        input  i_rdata, i_resp,
        output d_read, d_write, d_addr, d_wdata,
        input  d_rdata, d_resp,
        input  pmem_read, pmem_write, pmem_addr, pmem_wdata,
        output pmem_rdata, pmem_resp
    );

endinterface

// File: rtl/mem_arbiter_pick.sv
// mem_arb_pick: combinational grant selection between the I and D requesters.
// Build option MEM_ARB_RR_EN: when defined, contention goes to the requester
// that did not win last time; otherwise D always beats I.
module mem_arb_pick
    import mem_arb_types::*;
(
    input  logic     i_req,
    input  logic     d_req,
    input  arb_src_t last_grant,
    output arb_src_t o_src,
    output logic     o_valid
);

    // Pick a winner whenever at least one side is requesting.
    always_comb begin
        o_valid = i_req | d_req;
        o_src   = ARB_SRC_I;
`ifdef MEM_ARB_RR_EN
        if (i_req && d_req) begin
            o_src = (last_grant == ARB_SRC_I) ? ARB_SRC_D : ARB_SRC_I;
        end else if (d_req) begin
            o_src = ARB_SRC_D;
        end
`else
        if (d_req) begin
            o_src = ARB_SRC_D;
        end
`endif
    end

`ifndef MEM_ARB_RR_EN
    // Fixed priority has no use for the previous winner.
    logic w_unused_last_grant;
    assign w_unused_last_grant = last_grant;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single cacheline-wide memory port between the
// I-cache and the D-cache. One transaction at a time: the winner is latched in
// IDLE, the memory strobes are held from the latched copy until pmem_resp, the
// response goes to the winner only, and one RELEASE dead cycle follows.
// Build option MEM_ARB_RR_EN selects round-robin instead of fixed D-over-I.
module mem_arbiter
    import mem_arb_types::*;
#(
    parameter int LINE_WIDTH = ARB_LINE_WIDTH,
    parameter int ADDR_WIDTH = ARB_ADDR_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus,
    output arb_state_t   o_state
);

    arb_state_t            r_state;
    arb_state_t            w_state_next;
    logic                  w_latch;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [LINE_WIDTH-1:0] r_wdata;
    logic                  r_op_write;
    arb_src_t              w_grant_src;
    logic                  w_grant_valid;
    arb_src_t              w_last_grant;
    logic                  w_d_req;

    // A writeback and a fill share one D request; read+write together is
    // treated as a writeback.
    assign w_d_req = bus.d_read | bus.d_write;

    mem_arb_pick u_pick (
        .i_req      (bus.i_read),
        .d_req      (w_d_req),
        .last_grant (w_last_grant),
        .o_src      (w_grant_src),
        .o_valid    (w_grant_valid)
    );

`ifdef MEM_ARB_RR_EN
    arb_src_t r_last_grant;

    // Remember the most recent winner so contention flips to the other side.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= ARB_SRC_I;
        end else if (w_latch) begin
            r_last_grant <= w_grant_src;
        end
    end

    assign w_last_grant = r_last_grant;
`else
    assign w_last_grant = ARB_SRC_I;
`endif

    // Controller state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: grant in IDLE, wait for memory in SERVE, one dead cycle after.
    always_comb begin
        w_state_next = r_state;
        w_latch      = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                if (w_grant_valid) begin
                    w_latch      = 1'b1;
                    w_state_next = (w_grant_src == ARB_SRC_D) ? ARB_SERVE_D : ARB_SERVE_I;
                end
            end
            ARB_SERVE_I,
            ARB_SERVE_D: begin
                if (bus.pmem_resp) begin
                    w_state_next = ARB_RELEASE;
                end
            end
            ARB_RELEASE: begin
                w_state_next = ARB_IDLE;
            end
            default: begin
                w_state_next = ARB_IDLE;
            end
        endcase
    end

    // Capture the winner's request at grant; nothing the requester does while
    // being served reaches the memory port.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr     <= '0;
            r_wdata    <= '0;
            r_op_write <= 1'b0;
        end else if (w_latch) begin
            if (w_grant_src == ARB_SRC_D) begin
                r_addr     <= bus.d_addr;
                r_wdata    <= bus.d_wdata;
                r_op_write <= bus.d_write;
            end else begin
                r_addr     <= bus.i_addr;
                r_wdata    <= '0;
                r_op_write <= 1'b0;
            end
        end
    end

    // Memory strobes from the latched op; response routed to the owner only.
    always_comb begin
        bus.pmem_read  = 1'b0;
        bus.pmem_write = 1'b0;
        bus.pmem_addr  = r_addr;
        bus.pmem_wdata = r_wdata;
        bus.i_resp     = 1'b0;
        bus.i_rdata    = '0;
        bus.d_resp     = 1'b0;
        bus.d_rdata    = '0;
        case (r_state)
            ARB_SERVE_I: begin
                bus.pmem_read = 1'b1;
                if (bus.pmem_resp) begin
                    bus.i_resp  = 1'b1;
                    bus.i_rdata = bus.pmem_rdata;
                end
            end
            ARB_SERVE_D: begin
                bus.pmem_read  = ~r_op_write;
                bus.pmem_write = r_op_write;
                if (bus.pmem_resp) begin
                    bus.d_resp  = 1'b1;
                    bus.d_rdata = bus.pmem_rdata;
                end
            end
            default: begin
            end
        endcase
    end

    assign o_state = r_state;

`ifndef SYNTHESIS
    // A D-cache raising read and write together is a protocol violation; it is
    // served as a writeback but flagged here.
    a_d_read_write_both: assert property (
        @(posedge clk) disable iff (rst) !(bus.d_read && bus.d_write)
    ) else $warning("mem_arbiter: d_read and d_write both high, serving as writeback");
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized I/D traffic against a
// transaction-level reference of the arbitration rules and a line memory.
module tb_mem_arbiter;
    import mem_arb_types::*;

    localparam int LW = ARB_LINE_WIDTH;
    localparam int AW = ARB_ADDR_WIDTH;

    logic       clk = 1'b0;
    logic       rst;
    arb_state_t state;

    mem_arbiter_if bus ();

    mem_arbiter dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus.slave),
        .o_state (state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    task automatic do_reset();
        rst = 1'b1;
        bus.i_read = 1'b0; bus.d_read = 1'b0; bus.d_write = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
    endtask

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] v;
        for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [LW-1:0] init_line(input logic [AW-1:0] a);
        return {8{a ^ 32'hC0DE_0000}};
    endfunction

    // Memory device contents (what the responder holds) and the reference copy
    // (what the bench believes memory should hold).
    logic [LW-1:0] dev_mem [logic [AW-1:0]];
    logic [LW-1:0] ref_mem [logic [AW-1:0]];

    function automatic logic [LW-1:0] dev_line(input logic [AW-1:0] a);
        return dev_mem.exists(a) ? dev_mem[a] : init_line(a);
    endfunction

    function automatic logic [LW-1:0] ref_line(input logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_line(a);
    endfunction

    // ---------------- memory responder ----------------
    int   fixed_lat = 0;      // 0 -> random latency per transaction
    logic spur_req  = 1'b0;   // one-shot unsolicited pmem_resp

    initial begin
        int cnt;
        int lat;
        cnt = 0;
        lat = 1;
        bus.pmem_resp  = 1'b0;
        bus.pmem_rdata = '0;
        forever begin
            @(posedge clk); #2;
            if (rst) begin
                bus.pmem_resp = 1'b0;
                cnt = 0;
            end else if (bus.pmem_resp) begin
                bus.pmem_resp  = 1'b0;
                bus.pmem_rdata = rand_line();
                cnt = 0;
            end else if (spur_req) begin
                spur_req       = 1'b0;
                bus.pmem_resp  = 1'b1;
                bus.pmem_rdata = rand_line();
            end else if (bus.pmem_read || bus.pmem_write) begin
                if (cnt == 0) lat = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 6));
                cnt++;
                if (cnt >= lat) begin
                    bus.pmem_resp = 1'b1;
                    if (bus.pmem_write) dev_mem[bus.pmem_addr] = bus.pmem_wdata;
                    else bus.pmem_rdata = dev_line(bus.pmem_addr);
                end else begin
                    bus.pmem_rdata = rand_line();
                end
            end else begin
                bus.pmem_rdata = rand_line();
            end
        end
    end

    // ---------------- scoreboard / reference monitor ----------------
    // Rules modelled: a request seen while the port is free is granted and its
    // strobe shows up the next cycle; the port is free again two cycles after
    // a response; on contention D wins (or alternates under round-robin).
    logic          grant_q [$];   // 1 = D, 0 = I, in grant order
    logic          exp_q   [$];
    logic          in_txn    = 1'b0;
    logic          exp_start = 1'b0;
    logic          t_src, t_wr, model_last, pend_i, pend_d, strobe;
    logic [AW-1:0] t_addr;
    logic [LW-1:0] t_wdata;
    int            cyc = 0;
    int            last_resp = -10;
    int            n_iresp = 0;
    int            n_dresp = 0;

    initial begin
        model_last = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (bus.i_resp === 1'b1) n_iresp++;
            if (bus.d_resp === 1'b1) n_dresp++;
            if (rst) begin
                in_txn     = 1'b0;
                exp_start  = 1'b0;
                model_last = 1'b0;
                last_resp  = cyc - 1;
                continue;
            end
            strobe = bus.pmem_read | bus.pmem_write;
            if (exp_start) begin
                check("grant_strobe", strobe, 1'b1);
                exp_start = 1'b0;
                in_txn    = 1'b1;
                grant_q.push_back(t_src);
            end else if (!in_txn) begin
                check("no_strobe_when_free", strobe, 1'b0);
            end
            if (in_txn) begin
                check("pmem_addr", bus.pmem_addr, t_addr);
                check("pmem_read", bus.pmem_read, !t_wr);
                check("pmem_write", bus.pmem_write, t_wr);
                if (t_wr) check("pmem_wdata", bus.pmem_wdata, t_wdata);
            end
            if (in_txn && bus.pmem_resp) begin
                check("i_resp_owner", bus.i_resp, !t_src);
                check("d_resp_owner", bus.d_resp, t_src);
                if (t_src) begin
                    check("d_rdata", bus.d_rdata, t_wr ? bus.pmem_rdata : ref_line(t_addr));
                    check("i_rdata_idle", bus.i_rdata, '0);
                end else begin
                    check("i_rdata", bus.i_rdata, ref_line(t_addr));
                    check("d_rdata_idle", bus.d_rdata, '0);
                end
                if (t_wr) ref_mem[t_addr] = t_wdata;
                in_txn    = 1'b0;
                last_resp = cyc;
            end else begin
                check("i_resp_quiet", bus.i_resp, 1'b0);
                check("d_resp_quiet", bus.d_resp, 1'b0);
                check("i_rdata_quiet", bus.i_rdata, '0);
                check("d_rdata_quiet", bus.d_rdata, '0);
            end
            pend_i = bus.i_read;
            pend_d = bus.d_read | bus.d_write;
            if (!in_txn && cyc >= last_resp + 2 && (pend_i || pend_d)) begin
`ifdef MEM_ARB_RR_EN
                if (pend_i && pend_d) t_src = !model_last;
                else t_src = pend_d;
`else
                t_src = pend_d;
`endif
                model_last = t_src;
                t_addr     = t_src ? bus.d_addr : bus.i_addr;
                t_wr       = t_src ? bus.d_write : 1'b0;
                t_wdata    = bus.d_wdata;
                exp_start  = 1'b1;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic i_txn(input logic [AW-1:0] a, output logic [LW-1:0] rdata);
        logic got;
        got = 1'b0;
        rdata = '0;
        bus.i_read = 1'b1;
        bus.i_addr = a;
        for (int k = 0; k < 400 && !got; k++) begin
            @(negedge clk);
            if (bus.i_resp) begin got = 1'b1; rdata = bus.i_rdata; end
        end
        check("i_resp_arrived", got, 1'b1);
        @(posedge clk); #1;
        bus.i_read = 1'b0;
    endtask

    task automatic d_txn(input logic [AW-1:0] a, input logic [LW-1:0] wd, input logic rd,
                         input logic wr, input logic scramble, output logic [LW-1:0] rdata);
        logic got;
        got = 1'b0;
        rdata = '0;
        bus.d_read  = rd;
        bus.d_write = wr;
        bus.d_addr  = a;
        bus.d_wdata = wd;
        for (int k = 0; k < 400 && !got; k++) begin
            @(negedge clk);
            if (bus.d_resp) begin
                got = 1'b1;
                rdata = bus.d_rdata;
            end else if (scramble) begin
                @(posedge clk); #1;
                bus.d_addr  = $urandom;
                bus.d_wdata = rand_line();
            end
        end
        check("d_resp_arrived", got, 1'b1);
        @(posedge clk); #1;
        bus.d_read  = 1'b0;
        bus.d_write = 1'b0;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 200 && (in_txn || exp_start); k++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
    endtask

    function automatic logic [AW-1:0] rand_addr();
        return AW'($urandom_range(0, 15)) << 5;
    endfunction

    // Safety net so the run always ends.
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [LW-1:0] aa_line, wd2, wd6, rd_dummy;
        int base, ni, nd;

        aa_line = {32{8'hAA}};
        wd2     = {8{32'h1234_5678}};
        wd6     = {8{32'hFEED_BEEF}};
        dev_mem[32'h60] = aa_line;
        ref_mem[32'h60] = aa_line;

        rst = 1'b1;
        bus.i_read = 1'b0; bus.i_addr = '0;
        bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;

        // Reset state
        @(posedge clk);
        @(negedge clk);
        check("rst_state", state, ARB_IDLE);
        check("rst_pmem_read", bus.pmem_read, 1'b0);
        check("rst_pmem_write", bus.pmem_write, 1'b0);
        check("rst_pmem_addr", bus.pmem_addr, '0);
        check("rst_pmem_wdata", bus.pmem_wdata, '0);
        check("rst_resp", {bus.i_resp, bus.d_resp}, 2'b00);
        @(posedge clk); #1;
        rst = 1'b0;

        // 1: single I read, memory answers on the 5th strobe cycle
        fixed_lat = 5;
        ni = n_iresp; nd = n_dresp;
        i_txn(32'h0000_0060, rd_dummy);
        check("t1_i_rdata", rd_dummy, aa_line);
        check("t1_i_resp_count", n_iresp - ni, 1);
        check("t1_d_resp_count", n_dresp - nd, 0);
        fixed_lat = 0;
        wait_idle();

        // 2: D writeback with the address wandering during service
        fixed_lat = 4;
        d_txn(32'h8000_0100, wd2, 1'b0, 1'b1, 1'b1, rd_dummy);
        check("t2_mem_written", dev_line(32'h8000_0100), wd2);
        fixed_lat = 0;
        wait_idle();

        // 3: simultaneous I and D requests from a fresh reset
        do_reset();
        base = grant_q.size();
        fork
            i_txn(32'h0000_0200, rd_dummy);
            d_txn(32'h0000_0300, '0, 1'b1, 1'b0, 1'b0, rd_dummy);
        join
        wait_idle();
        exp_q = {1'b1, 1'b0};
        check("t3_grant_count", grant_q.size() - base, 2);
        for (int k = 0; k < 2; k++)
            if (base + k < grant_q.size()) check("t3_grant_order", grant_q[base + k], exp_q[k]);

        // 4: continuous contention over four grants
        do_reset();
        base = grant_q.size();
        bus.d_read = 1'b1; bus.d_addr = 32'h0000_0500;
        bus.i_read = 1'b1; bus.i_addr = 32'h0000_0600;
        for (int k = 0; k < 300 && grant_q.size() < base + 4; k++) @(posedge clk);
        #1;
        bus.d_read = 1'b0;
        bus.i_read = 1'b0;
        wait_idle();
`ifdef MEM_ARB_RR_EN
        exp_q = {1'b1, 1'b0, 1'b1, 1'b0};
`else
        exp_q = {1'b1, 1'b1, 1'b1, 1'b1};
`endif
        check("t4_enough_grants", grant_q.size() >= base + 4, 1'b1);
        for (int k = 0; k < 4; k++)
            if (base + k < grant_q.size()) check("t4_grant_seq", grant_q[base + k], exp_q[k]);

        // 5: reset two cycles into an I read, then a stray pmem_resp
        fixed_lat = 20;
        ni = n_iresp;
        bus.i_read = 1'b1; bus.i_addr = 32'h0000_0400;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        bus.i_read = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("t5_state_idle", state, ARB_IDLE);
        check("t5_strobes_low", {bus.pmem_read, bus.pmem_write}, 2'b00);
        @(posedge clk); #1;
        spur_req = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        check("t5_no_i_resp", n_iresp - ni, 0);
        fixed_lat = 0;

        // 6: stray pmem_resp in IDLE, then read+write together
        ni = n_iresp; nd = n_dresp;
        spur_req = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        check("t6_spurious_ignored", (n_iresp - ni) + (n_dresp - nd), 0);
        d_txn(32'h0000_0700, wd6, 1'b1, 1'b1, 1'b0, rd_dummy);
        check("t6_rw_is_write", dev_line(32'h0000_0700), wd6);
        wait_idle();

        // Randomized concurrent traffic
        fork
            begin
                logic [LW-1:0] r;
                for (int n = 0; n < 30; n++) begin
                    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                    i_txn(rand_addr(), r);
                end
            end
            begin
                logic [LW-1:0] r;
                logic          w;
                for (int n = 0; n < 30; n++) begin
                    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                    w = 1'($urandom_range(0, 1));
                    d_txn(rand_addr(), rand_line(), !w, w, 1'($urandom_range(0, 1)), r);
                end
            end
        join
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
